// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared operand word layout and scheduler state encoding for the adder
package adder_pkg;

  localparam int W_INS = 33;
  localparam int W_SM  = 10;
  localparam int W_OP  = 16;
  localparam int W_X   = 8;

  // The x view of an operand is its low byte and the y view is the whole 16-bit field.
  // So s1.x=[7:0], s1.y=[15:0], cin=[16], s2.x=[24:17], s2.y=[32:17].
  typedef struct packed {
    logic [W_OP-1:0] s2;
    logic            cin;
    logic [W_OP-1:0] s1;
  } adder_ins_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [W_X-1:0] op_x(input logic [W_OP-1:0] op);
    return op[W_X-1:0];
  endfunction

  function automatic logic [W_OP-1:0] op_y(input logic [W_OP-1:0] op);
    return op;
  endfunction

endpackage

// File: rtl/adder_sched_rr_arbiter.sv
// rtl/adder_sched_rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);

  localparam int IW = $clog2(NREQ);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_sched.sv
// rtl/adder_sched.sv - round-robin scheduler sharing one registered adder among NREQ requesters
module adder_sched #(
  parameter int NREQ  = 4,
  parameter int W_INS = adder_pkg::W_INS,
  parameter int W_SM  = adder_pkg::W_SM
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W_INS-1:0]    req_ins,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [W_SM-1:0]          rsp_sm,
  output logic                     rsp_zero,
  output logic                     busy,
  output logic [W_INS-1:0]         add_ins,
  input  logic [W_SM-1:0]          add_sm_r,
  input  logic                     add_sm_zero_r
);

  import adder_pkg::*;

  localparam int IW = $clog2(NREQ);

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [NREQ-1:0]  win_gnt;
  logic [IW-1:0]    win_idx;
  logic [W_INS-1:0] sel_ins;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (win_gnt),
    .gnt_idx (win_idx)
  );

  // Grant is offered only while idle and out of reset, so at most one op is ever in flight.
  assign req_ready = (rst_n && state == IDLE) ? win_gnt : '0;

  always_comb begin
    sel_ins = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) sel_ins = req_ins[i*W_INS +: W_INS];
    end
  end

  // The adder result is consumed straight from its output register; add_ins is held through RESP.
  assign rsp_sm   = add_sm_r;
  assign rsp_zero = add_sm_zero_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      add_ins   <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            add_ins <= sel_ins;
            rsp_id  <= win_idx;
            rr_ptr  <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
